// File: rtl/tone_freq_detector.sv
// Tone frequency detector: measures the zero-crossing period of a sampled tone with hysteresis,
// then divides 2^PHASE_WIDTH by that period to produce the matching DDS tuning word.
`timescale 1ns/1ps
module tone_freq_detector #(
  parameter int PHASE_WIDTH  = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 24,
  parameter int HYST         = 256
) (
  input  logic                    clk,
  input  logic                    rst_active_low,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic [PERIOD_WIDTH-1:0] period_out,
  output logic [PHASE_WIDTH-1:0]  freq_word_out,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout
);
  localparam int                            ITER_W     = $clog2(PHASE_WIDTH + 2);
  localparam logic [ITER_W-1:0]             ITER_LOAD  = ITER_W'(PHASE_WIDTH + 1);
  localparam logic [PERIOD_WIDTH-1:0]       COUNT_LAST = {{(PERIOD_WIDTH-1){1'b1}}, 1'b0};
  localparam logic signed [DATA_WIDTH-1:0]  NEG_HYST   = DATA_WIDTH'(-HYST);

  typedef enum logic {SEEK, TRACK} meas_state_t;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  meas_state_t             r_meas;
  div_state_t              r_div;
  logic                    r_armed;
  logic [PERIOD_WIDTH-1:0] r_count;
  logic                    r_overrun;
  logic                    r_timeout;
  logic                    r_busy;
  logic                    r_result_valid;
  logic [ITER_W-1:0]       r_iter;
  logic [PERIOD_WIDTH:0]   r_rem;
  logic [PHASE_WIDTH-1:0]  r_quot;
  logic [PERIOD_WIDTH-1:0] r_divisor;
  logic [PERIOD_WIDTH-1:0] r_period_out;
  logic [PHASE_WIDTH-1:0]  r_freq_out;

  logic                    w_below;
  logic                    w_cross;
  logic                    w_start;
  logic                    w_dividend_bit;
  logic                    w_ge;
  logic [PERIOD_WIDTH:0]   w_rem_shift;
  logic [PERIOD_WIDTH:0]   w_rem_sub;

  assign w_below = $signed(sample_in) < NEG_HYST;
  assign w_cross = sample_valid & r_armed & ~sample_in[DATA_WIDTH-1];
  assign w_start = w_cross & (r_meas == TRACK) & ~r_busy;

  // Dividend is a single 1 followed by PHASE_WIDTH zeros; it enters on the first iteration only.
  assign w_dividend_bit = (r_iter == ITER_LOAD);
  assign w_rem_shift    = {r_rem[PERIOD_WIDTH-1:0], w_dividend_bit};
  assign w_ge           = r_rem[PERIOD_WIDTH] | (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_sub      = w_rem_shift - {1'b0, r_divisor};

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      r_meas    <= SEEK;
      r_armed   <= 1'b0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      if (sample_valid) begin
        if (w_cross) begin
          r_armed <= 1'b0;
        end else if (w_below) begin
          r_armed <= 1'b1;
        end
        case (r_meas)
          SEEK: begin
            if (w_cross) begin
              r_meas  <= TRACK;
              r_count <= PERIOD_WIDTH'(1);
            end
          end
          TRACK: begin
            if (w_cross) begin
              r_count <= PERIOD_WIDTH'(1);
              if (r_busy) r_overrun <= 1'b1;
            end else if (r_count == COUNT_LAST) begin
              // Count would saturate: give up on this tone and re-acquire.
              r_timeout <= 1'b1;
              r_meas    <= SEEK;
              r_armed   <= 1'b0;
              r_count   <= '0;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      r_div          <= DIV_IDLE;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_iter         <= '0;
      r_rem          <= '0;
      r_quot         <= '0;
      r_divisor      <= '0;
      r_period_out   <= '0;
      r_freq_out     <= '0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_div)
        DIV_IDLE, DIV_DONE: begin
          if (w_start) begin
            r_div     <= DIV_RUN;
            r_busy    <= 1'b1;
            r_iter    <= ITER_LOAD;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= r_count;
          end else begin
            r_div <= DIV_IDLE;
          end
        end
        DIV_RUN: begin
          if (r_iter != '0) begin
            r_rem  <= w_ge ? w_rem_sub : w_rem_shift;
            r_quot <= {r_quot[PHASE_WIDTH-2:0], w_ge};
            r_iter <= r_iter - 1'b1;
          end else begin
            r_div          <= DIV_DONE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b1;
            r_period_out   <= r_divisor;
            r_freq_out     <= r_quot;
          end
        end
        default: r_div <= DIV_IDLE;
      endcase
    end
  end

  assign period_out    = r_period_out;
  assign freq_word_out = r_freq_out;
  assign result_valid  = r_result_valid;
  assign busy          = r_busy;
  assign overrun       = r_overrun;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_tone_freq_detector.sv
// Bench for tone_freq_detector: randomized tone/noise stimulus scored every cycle against a
// timeline model of crossings, periods and divider completion times.
`timescale 1ns/1ps
module tb_tone_freq_detector;
  localparam int HYST = 256;
  localparam int LAT  = 34;

  logic        clk = 1'b0;
  logic        rst_active_low;
  logic [15:0] s0, s8;
  logic        v0, v8;
  logic [23:0] period0;
  logic [7:0]  period8;
  logic [31:0] freq0, freq8;
  logic        rv0, busy0, ov0, to0;
  logic        rv8, busy8, ov8, to8;

  always #5 clk = ~clk;

  tone_freq_detector dut (
    .clk(clk), .rst_active_low(rst_active_low), .sample_in(s0), .sample_valid(v0),
    .period_out(period0), .freq_word_out(freq0), .result_valid(rv0), .busy(busy0),
    .overrun(ov0), .timeout(to0)
  );

  tone_freq_detector #(.PERIOD_WIDTH(8)) dut8 (
    .clk(clk), .rst_active_low(rst_active_low), .sample_in(s8), .sample_valid(v8),
    .period_out(period8), .freq_word_out(freq8), .result_valid(rv8), .busy(busy8),
    .overrun(ov8), .timeout(to8)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     m_edge = 0;
  bit     m_track[2], m_armed[2], m_dact[2];
  int     m_idx[2], m_last[2], m_dstart[2], m_dper[2];
  bit     e_rv[2], e_busy[2], e_ov[2], e_to[2];
  longint e_per[2], e_freq[2];
  int     cnt_rv[2], cnt_ov[2], cnt_to[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_track[u] = 0; m_armed[u] = 0; m_dact[u] = 0;
      m_idx[u] = 0; m_last[u] = 0; m_dstart[u] = 0; m_dper[u] = 0;
      e_rv[u] = 0; e_busy[u] = 0; e_ov[u] = 0; e_to[u] = 0;
      e_per[u] = 0; e_freq[u] = 0;
      cnt_rv[u] = 0; cnt_ov[u] = 0; cnt_to[u] = 0;
    end
  endtask

  // Timeline model: a result appears LAT edges after the crossing that ends a period,
  // and the divider is free again only after that result edge.
  task automatic model_step(input int u, input bit v, input int s);
    int maxc;
    int per;
    bit start;
    maxc = (u == 0) ? (1 << 24) - 1 : 255;
    e_rv[u] = 0; e_ov[u] = 0; e_to[u] = 0;
    start = 0; per = 0;
    if (v) begin
      if (m_armed[u] && s >= 0) begin
        if (m_track[u]) begin
          per = m_idx[u] - m_last[u];
          if (m_dact[u]) e_ov[u] = 1;
          else start = 1;
        end
        m_track[u] = 1;
        m_last[u]  = m_idx[u];
        m_armed[u] = 0;
      end else begin
        if (s < -HYST) m_armed[u] = 1;
        if (m_track[u] && (m_idx[u] - m_last[u]) == maxc - 1) begin
          e_to[u] = 1; m_track[u] = 0; m_armed[u] = 0;
        end
      end
      m_idx[u]++;
    end
    if (m_dact[u] && m_edge == m_dstart[u] + LAT) begin
      e_rv[u]   = 1;
      e_per[u]  = m_dper[u];
      e_freq[u] = (longint'(1) << 32) / m_dper[u];
      m_dact[u] = 0;
    end
    if (start) begin
      m_dact[u] = 1; m_dstart[u] = m_edge; m_dper[u] = per;
    end
    e_busy[u] = m_dact[u];
  endtask

  task automatic do_reset(input int n);
    rst_active_low = 1'b0;
    #1;
    check_eq("rst_period0", {40'b0, period0}, 64'd0);
    check_eq("rst_freq0", {32'b0, freq0}, 64'd0);
    check_eq("rst_flags0", {60'b0, rv0, busy0, ov0, to0}, 64'd0);
    check_eq("rst_period8", {56'b0, period8}, 64'd0);
    check_eq("rst_freq8", {32'b0, freq8}, 64'd0);
    check_eq("rst_flags8", {60'b0, rv8, busy8, ov8, to8}, 64'd0);
    model_reset();
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_active_low = 1'b1;
  endtask

  task automatic step(input bit va, input int sa, input bit vb, input int sb);
    v0 = va; s0 = sa[15:0];
    v8 = vb; s8 = sb[15:0];
    @(posedge clk);
    m_edge++;
    model_step(0, va, sa);
    model_step(1, vb, sb);
    #1;
    check_eq($sformatf("flags0@%0d", m_edge), {60'b0, rv0, busy0, ov0, to0},
             {60'b0, e_rv[0], e_busy[0], e_ov[0], e_to[0]});
    check_eq($sformatf("data0@%0d", m_edge), {8'b0, period0, freq0}, (e_per[0] << 32) | e_freq[0]);
    check_eq($sformatf("flags8@%0d", m_edge), {60'b0, rv8, busy8, ov8, to8},
             {60'b0, e_rv[1], e_busy[1], e_ov[1], e_to[1]});
    check_eq($sformatf("data8@%0d", m_edge), {24'b0, period8, freq8}, (e_per[1] << 32) | e_freq[1]);
    cnt_rv[0] += int'(rv0); cnt_ov[0] += int'(ov0); cnt_to[0] += int'(to0);
    cnt_rv[1] += int'(rv8); cnt_ov[1] += int'(ov8); cnt_to[1] += int'(to8);
  endtask

  function automatic int sine_val(input int k, input int per, input int amp, input real ph);
    real x;
    x = amp * $sin(6.283185307179586 * (k + ph) / per);
    return int'(x);
  endfunction

  function automatic int garbage();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Drives dut only; invalid cycles carry random garbage that must be ignored.
  task automatic run_sine(input int per, input int amp, input int n, input int every, input real ph);
    int k;
    k = 0;
    for (int c = 0; c < n; c++) begin
      if (c % every == 0) begin
        step(1'b1, sine_val(k, per, amp, ph), 1'b0, 0);
        k++;
      end else begin
        step(1'b0, garbage(), 1'b0, 0);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    real ph;
    int  k, per, amp, seg, s, found;
    rst_active_low = 1'b1;
    v0 = 1'b0; s0 = '0; v8 = 1'b0; s8 = '0;
    model_reset();
    #2;
    do_reset(4);

    ph = real'($urandom_range(0, 999)) / 1000.0;
    run_sine(64, 16000, 64 * 7, 1, ph);
    check_eq("p64_period", {40'b0, period0}, 64'd64);
    check_eq("p64_freq", {32'b0, freq0}, 64'h0400_0000);
    check_eq("p64_result_count_ge4", {63'b0, cnt_rv[0] >= 4}, 64'd1);

    do_reset(3);
    ph = real'($urandom_range(0, 999)) / 1000.0;
    run_sine(100, 16000, 100 * 2 * 6, 2, ph);
    check_eq("p100_period", {40'b0, period0}, 64'd100);
    check_eq("p100_freq", {32'b0, freq0}, 64'd42949672);

    do_reset(3);
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 400)) - 200, 1'b0, 0);
    check_eq("noise_results", cnt_rv[0], 0);
    check_eq("noise_timeouts", cnt_to[0], 0);

    do_reset(3);
    ph = real'($urandom_range(0, 999)) / 1000.0;
    run_sine(8, 16000, 400, 1, ph);
    check_eq("p8_overrun_seen", {63'b0, cnt_ov[0] > 0}, 64'd1);
    check_eq("p8_period", {40'b0, period0}, 64'd8);
    check_eq("p8_freq", {32'b0, freq0}, 64'h2000_0000);

    do_reset(3);
    for (int c = 0; c < 100; c++) step(1'b1, (c % 2 == 1) ? 1000 : -1000, 1'b0, 0);
    check_eq("p2_period", {40'b0, period0}, 64'd2);
    check_eq("p2_freq", {32'b0, freq0}, 64'h8000_0000);

    do_reset(3);
    ph = real'($urandom_range(0, 999)) / 1000.0;
    found = 0; k = 0;
    for (int c = 0; c < 500 && found == 0; c++) begin
      step(1'b1, sine_val(k, 64, 16000, ph), 1'b0, 0);
      k++;
      if (m_dact[0] && m_edge == m_dstart[0] + 10) found = 1;
    end
    check_eq("middiv_reached", found, 1);
    do_reset(3);
    run_sine(64, 16000, 64 * 3 + 40, 1, ph);
    check_eq("middiv_result_after_two_crossings", {63'b0, cnt_rv[0] >= 1}, 64'd1);

    do_reset(3);
    step(1'b0, 0, 1'b1, -1000);
    step(1'b0, 0, 1'b1, 1000);
    for (int c = 0; c < 300; c++) step(1'b0, 0, 1'b1, 1000);
    check_eq("w8_timeouts", cnt_to[1], 1);
    check_eq("w8_results", cnt_rv[1], 0);

    do_reset(3);
    k = 0; per = 64; amp = 16000; seg = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg == 0) begin
        per = int'($urandom_range(2, 150));
        amp = int'($urandom_range(300, 20000));
        seg = int'($urandom_range(100, 300));
      end
      seg--;
      s = sine_val(k, per, amp, 0.25) + int'($urandom_range(0, 200)) - 100;
      if ($urandom_range(0, 7) != 0) begin
        step(1'b1, s, 1'b1, s);
        k++;
      end else begin
        step(1'b0, garbage(), 1'b0, garbage());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
